// File: rtl/wb_master.sv
// wb_master: Wishbone B4 classic-cycle initiator.
// Bridges a valid/ready core request onto the Wishbone bus. Handles single
// reads/writes and incrementing read bursts of up to 4 beats (CTI tagged).
// Emits one response pulse per beat. A per-beat timeout turns a hung slave
// into an error response.
module wb_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_be,
    input  logic [1:0]  i_req_len,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_rsp_last,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    output logic [2:0]  o_wb_cti,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data
);

    localparam logic [0:0]  S_IDLE      = 1'b0;
    localparam logic [0:0]  S_ACTIVE    = 1'b1;
    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    localparam logic [2:0]  CTI_INCR    = 3'b010;
    localparam logic [2:0]  CTI_END     = 3'b111;
    // Counter value seen in the final allowed stb cycle of a beat.
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

    logic [0:0]  r_state;
    logic        r_cyc;
    logic        r_stb;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_sel;
    logic [2:0]  r_cti;
    logic [2:0]  r_beats;      // beats remaining, including the one on the bus
    logic [15:0] r_tmo;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic        r_rsp_last;

    logic [2:0]  w_beats_new;
    logic        w_abort;

    // Writes are always a single beat; reads carry len+1 beats.
    assign w_beats_new = i_req_we ? 3'd1 : ({1'b0, i_req_len} + 3'd1);
    // Slave error wins over ack; a timeout only fires if the final allowed
    // cycle did not bring an ack.
    assign w_abort     = i_wb_err || (!i_wb_ack && (r_tmo == TMO_LAST));

    assign o_req_ready = (r_state == S_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_last  = r_rsp_last;
    assign o_wb_cyc    = r_cyc;
    assign o_wb_stb    = r_stb;
    assign o_wb_we     = r_we;
    assign o_wb_addr   = r_addr;
    assign o_wb_data   = r_data;
    assign o_wb_sel    = r_sel;
    assign o_wb_cti    = r_cti;

    // Request acceptance, beat sequencing, termination and response generation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_data      <= 32'h0;
            r_sel       <= 4'h0;
            r_cti       <= CTI_CLASSIC;
            r_beats     <= 3'd0;
            r_tmo       <= 16'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_we    <= i_req_we;
                        r_addr  <= i_req_addr;
                        r_data  <= i_req_wdata;
                        r_sel   <= i_req_be;
                        r_beats <= w_beats_new;
                        r_cti   <= (w_beats_new == 3'd1) ? CTI_CLASSIC : CTI_INCR;
                        r_tmo   <= 16'h0;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_state <= S_ACTIVE;
                    end
                end
                default: begin
                    if (w_abort) begin
                        // Remaining beats of the request are discarded.
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_last  <= 1'b1;
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (i_wb_ack) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_we ? 32'h0 : i_wb_data;
                        r_rsp_last  <= (r_beats == 3'd1);
                        if (r_beats == 3'd1) begin
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_addr  <= r_addr + 32'd4;
                            r_beats <= r_beats - 3'd1;
                            r_tmo   <= 16'h0;
                            if (r_beats == 3'd2)
                                r_cti <= CTI_END;
                        end
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master.sv
// Scoreboard bench for wb_master: stimulus pushes expected responses and
// bus beats into queues; a negedge monitor pops and compares them.
module tb_wb_master;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        last;
        int          lat;       // cycles after acceptance, -1 = don't care
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  cti;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        chk_wd;
    } beat_t;

    localparam int M_COMB = 0, M_REG = 1, M_NONE = 2, M_ERRB = 3, M_BOTH = 4, M_LATE = 5;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [31:0] i_req_addr = 32'h0;
    logic [31:0] i_req_wdata = 32'h0;
    logic [3:0]  i_req_be = 4'h0;
    logic [1:0]  i_req_len = 2'd0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;
    logic        o_rsp_last;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic [3:0]  o_wb_sel;
    logic [2:0]  o_wb_cti;
    logic        wb_ack, wb_err;
    logic [31:0] wb_rdata;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc_n = 0;
    int          acc_cyc = 0;
    int          stb_cnt = 0;
    int          slv_mode = M_COMB;
    int          err_beat = 1;
    logic        slv_addr_data = 1'b0;
    logic [31:0] slv_data = 32'h0;
    logic        r_ack = 1'b0;
    int          stb_run = 0;
    int          slv_beat = 0;
    rsp_t        exp_rsp[$];
    beat_t       exp_beat[$];

    wb_master #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .i_req_be(i_req_be), .i_req_len(i_req_len),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .o_rsp_err(o_rsp_err), .o_rsp_last(o_rsp_last),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .o_wb_cti(o_wb_cti),
        .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc_n <= cyc_n + 1;

    // Slave model.
    always_comb begin
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_rdata = slv_addr_data ? {16'hB000, o_wb_addr[15:0]} : slv_data;
        case (slv_mode)
            M_COMB: wb_ack = o_wb_stb;
            M_REG:  wb_ack = r_ack;
            M_ERRB: begin
                if (o_wb_stb && slv_beat == err_beat) wb_err = 1'b1;
                else                                  wb_ack = o_wb_stb;
            end
            M_BOTH: begin wb_ack = o_wb_stb; wb_err = o_wb_stb; end
            M_LATE: wb_ack = o_wb_stb && (stb_run == 7);
            default: ;
        endcase
    end

    always @(posedge i_clk) begin
        r_ack    <= (slv_mode == M_REG) && o_wb_stb && !r_ack;
        stb_run  <= (o_wb_stb && !(wb_ack || wb_err)) ? stb_run + 1 : 0;
        slv_beat <= !o_wb_cyc ? 0 : ((o_wb_stb && (wb_ack || wb_err)) ? slv_beat + 1 : slv_beat);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Monitor: response and bus-beat scoreboards.
    always @(negedge i_clk) begin
        if (o_wb_stb) stb_cnt++;
        if (o_rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                chk("rsp_data", o_rsp_data, e.data);
                chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, e.err});
                chk("rsp_last", {31'd0, o_rsp_last}, {31'd0, e.last});
                if (e.lat >= 0) chk("rsp_latency", cyc_n - acc_cyc, e.lat);
            end
        end
        if (o_wb_stb && (wb_ack || wb_err)) begin
            if (exp_beat.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                beat_t b;
                b = exp_beat.pop_front();
                chk("wb_addr", o_wb_addr, b.addr);
                chk("wb_cti", {29'd0, o_wb_cti}, {29'd0, b.cti});
                chk("wb_we", {31'd0, o_wb_we}, {31'd0, b.we});
                chk("wb_sel", {28'd0, o_wb_sel}, {28'd0, b.sel});
                chk("wb_cyc", {31'd0, o_wb_cyc}, 32'd1);
                if (b.chk_wd) chk("wb_wdata", o_wb_data, b.wdata);
            end
        end
    end

    task automatic push_rsp(input logic [31:0] d, input logic e, input logic l, input int lat);
        rsp_t r;
        r.data = d; r.err = e; r.last = l; r.lat = lat;
        exp_rsp.push_back(r);
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [2:0] c, input logic we,
                             input logic [3:0] s, input logic [31:0] wd, input logic cw);
        beat_t b;
        b.addr = a; b.cti = c; b.we = we; b.sel = s; b.wdata = wd; b.chk_wd = cw;
        exp_beat.push_back(b);
    endtask

    // Drive one request; returns just after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [1:0] len);
        int n;
        n = 0;
        @(negedge i_clk);
        while (!o_req_ready && n < 100) begin @(negedge i_clk); n++; end
        if (!o_req_ready) chk("ready_timeout", 32'd0, 32'd1);
        i_req_we = we; i_req_addr = addr; i_req_wdata = wd; i_req_be = be; i_req_len = len;
        i_req_valid = 1'b1;
        @(posedge i_clk);
        #1;
        acc_cyc = cyc_n;
        i_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge i_clk);
        while (!(o_req_ready && exp_rsp.size() == 0) && n < 200) begin @(negedge i_clk); n++; end
        chk({name, "_done"}, {31'd0, o_req_ready && exp_rsp.size() == 0}, 32'd1);
        chk({name, "_beats_left"}, exp_beat.size(), 32'd0);
        chk({name, "_cyc_idle"}, {31'd0, o_wb_cyc}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
        chk("rst_cyc_stb_we", {29'd0, o_wb_cyc, o_wb_stb, o_wb_we}, 32'd0);
        chk("rst_addr", o_wb_addr, 32'd0);
        chk("rst_wdata", o_wb_data, 32'd0);
        chk("rst_sel_cti", {25'd0, o_wb_sel, o_wb_cti}, 32'd0);
        chk("rst_rsp", {29'd0, o_rsp_valid, o_rsp_err, o_rsp_last}, 32'd0);
        chk("rst_rsp_data", o_rsp_data, 32'd0);

        // Single read, combinational slave.
        slv_mode = M_COMB; slv_addr_data = 1'b0; slv_data = 32'hDEADBEEF;
        push_beat(32'h10000004, 3'b000, 1'b0, 4'hF, 32'h0, 1'b0);
        push_rsp(32'hDEADBEEF, 1'b0, 1'b1, 1);
        s0 = stb_cnt;
        issue(1'b0, 32'h10000004, 32'h0, 4'hF, 2'd0);
        wait_idle("rd_single");
        chk("rd_single_stb_cycles", stb_cnt - s0, 32'd1);

        // Write with partial byte enables, registered slave; len is ignored.
        slv_mode = M_REG; slv_data = 32'hCAFEF00D;
        push_beat(32'h10000008, 3'b000, 1'b1, 4'b0011, 32'h12345678, 1'b1);
        push_rsp(32'h0, 1'b0, 1'b1, 2);
        s0 = stb_cnt;
        issue(1'b1, 32'h10000008, 32'h12345678, 4'b0011, 2'd3);
        wait_idle("wr_reg");
        chk("wr_reg_stb_cycles", stb_cnt - s0, 32'd2);

        // 4-beat burst wrapping past the top of the address space.
        slv_mode = M_COMB; slv_addr_data = 1'b1;
        push_beat(32'hFFFFFFF8, 3'b010, 1'b0, 4'hF, 32'h0, 1'b0);
        push_beat(32'hFFFFFFFC, 3'b010, 1'b0, 4'hF, 32'h0, 1'b0);
        push_beat(32'h00000000, 3'b010, 1'b0, 4'hF, 32'h0, 1'b0);
        push_beat(32'h00000004, 3'b111, 1'b0, 4'hF, 32'h0, 1'b0);
        push_rsp(32'hB000FFF8, 1'b0, 1'b0, 1);
        push_rsp(32'hB000FFFC, 1'b0, 1'b0, 2);
        push_rsp(32'hB0000000, 1'b0, 1'b0, 3);
        push_rsp(32'hB0000004, 1'b0, 1'b1, 4);
        s0 = stb_cnt;
        issue(1'b0, 32'hFFFFFFF8, 32'h0, 4'hF, 2'd3);
        wait_idle("burst4");
        chk("burst4_stb_cycles", stb_cnt - s0, 32'd4);

        // Burst with slave error on the second beat.
        slv_mode = M_ERRB; err_beat = 1;
        push_beat(32'h20000000, 3'b010, 1'b0, 4'hF, 32'h0, 1'b0);
        push_beat(32'h20000004, 3'b010, 1'b0, 4'hF, 32'h0, 1'b0);
        push_rsp(32'hB0000000, 1'b0, 1'b0, 1);
        push_rsp(32'h0, 1'b1, 1'b1, 2);
        issue(1'b0, 32'h20000000, 32'h0, 4'hF, 2'd3);
        wait_idle("burst_err");

        // ack and err together: err wins.
        slv_mode = M_BOTH;
        push_beat(32'h30000000, 3'b000, 1'b0, 4'hF, 32'h0, 1'b0);
        push_rsp(32'h0, 1'b1, 1'b1, 1);
        issue(1'b0, 32'h30000000, 32'h0, 4'hF, 2'd0);
        wait_idle("ack_err");

        // Silent slave: timeout after exactly 8 stb cycles.
        slv_mode = M_NONE;
        push_rsp(32'h0, 1'b1, 1'b1, 8);
        s0 = stb_cnt;
        issue(1'b0, 32'h40000000, 32'h0, 4'hF, 2'd0);
        wait_idle("timeout");
        chk("timeout_stb_cycles", stb_cnt - s0, 32'd8);

        // Ack in the final allowed cycle completes normally.
        slv_mode = M_LATE; slv_addr_data = 1'b0; slv_data = 32'h0BADF00D;
        push_beat(32'h40000010, 3'b000, 1'b0, 4'hF, 32'h0, 1'b0);
        push_rsp(32'h0BADF00D, 1'b0, 1'b1, 8);
        s0 = stb_cnt;
        issue(1'b0, 32'h40000010, 32'h0, 4'hF, 2'd0);
        wait_idle("late_ack");
        chk("late_ack_stb_cycles", stb_cnt - s0, 32'd8);

        // Reset during beat 2 of a 4-beat burst.
        slv_mode = M_COMB; slv_addr_data = 1'b1;
        push_beat(32'h50000000, 3'b010, 1'b0, 4'hF, 32'h0, 1'b0);
        push_beat(32'h50000004, 3'b010, 1'b0, 4'hF, 32'h0, 1'b0);
        push_rsp(32'hB0000000, 1'b0, 1'b0, 1);
        issue(1'b0, 32'h50000000, 32'h0, 4'hF, 2'd3);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst_mid_cyc_stb", {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
        chk("rst_mid_ready", {31'd0, o_req_ready}, 32'd1);
        repeat (4) @(negedge i_clk);
        chk("rst_mid_rsp_left", exp_rsp.size(), 32'd0);
        chk("rst_mid_beats_left", exp_beat.size(), 32'd0);

        // Normal single read after the reset.
        slv_addr_data = 1'b0; slv_data = 32'h600DCAFE;
        push_beat(32'h60000000, 3'b000, 1'b0, 4'hF, 32'h0, 1'b0);
        push_rsp(32'h600DCAFE, 1'b0, 1'b1, 1);
        issue(1'b0, 32'h60000000, 32'h0, 4'hF, 2'd0);
        wait_idle("post_rst");

        repeat (3) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
